word_serializer: RTL and testbench

- Upstream feeder for the consecutive-ones group counter.
- Accepts parallel words over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Shifts each word out one bit at a time on a serial line with framing strobes. The serial line drives the counter's `din` directly.
- Optional forced-zero gap bits between words stop ones runs in adjacent words from merging into one group downstream.

---
 rtl/word_serializer.sv | 208 ++++++++++++++++++++
 tb/tb_word_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer
//   Takes parallel words over a valid/ready handshake, queues them in a
//   2-entry FIFO and shifts each one out bit-serially with framing strobes.
//   Optional forced-zero gap bits after each word keep ones-runs of adjacent
//   words from merging into a single group in the downstream counter.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_data     parallel word (WIDTH bits)
//   in_valid    in_data is valid
//   in_ready    word can be accepted this cycle (registered, = !fifo_full)
//   dout        serial bit, feeds the group counter's din
//   dout_valid  dout carries a data bit or a gap bit
//   word_start  high during the first bit period of each word
//   word_end    high during the last data bit period of each word
//   busy        shifter active or FIFO non-empty
//   words_sent  count of fully transmitted words, wraps modulo 256
//
// Every output is a flop. The next-state and output processes compute the
// values the registers take on the coming edge, so nothing reaches a port
// combinationally.
module word_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_BITS   = 0,
  parameter int BIT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_start,
  output logic             word_end,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_n;

  // FIFO storage, kept apart from the shift register
  logic [WIDTH-1:0] fifo_mem [2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       fifo_cnt, fifo_cnt_n;
  logic             fifo_empty;

  // shifter and timing counters
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [3:0]       per_cnt, per_cnt_n;
  logic [3:0]       gap_cnt, gap_cnt_n;

  logic per_last, bit_last, gap_last;
  logic push, load, word_done;

  // next values of the registered outputs
  logic       dout_n, dout_valid_n, word_start_n, word_end_n, busy_n, in_ready_n;
  logic [7:0] words_sent_n;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign push       = in_valid && in_ready;
  assign per_last   = (per_cnt == 4'(BIT_PERIOD - 1));
  assign bit_last   = (bit_cnt == BW'(WIDTH - 1));
  // With GAP_BITS=0 this compares against 4'hF, but GAP is unreachable then.
  assign gap_last   = (gap_cnt == 4'(GAP_BITS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state; also decides when the FIFO head is loaded and when a
  // word's data bits are complete.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (per_last && bit_last) begin
          word_done = 1'b1;
          if (GAP_BITS > 0)     state_n = GAP;
          else if (!fifo_empty) load    = 1'b1;   // no bubble between words
          else                  state_n = IDLE;
        end
      end
      GAP: begin
        if (per_last && gap_last) begin
          if (!fifo_empty) begin
            state_n = SHIFT;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: shifter, bit/period/gap counters, FIFO occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    per_cnt_n = per_cnt;
    gap_cnt_n = gap_cnt;
    if (load) begin
      shreg_n   = fifo_mem[rd_ptr];
      bit_cnt_n = '0;
      per_cnt_n = '0;
    end else if (state != IDLE) begin
      per_cnt_n = per_last ? 4'd0 : per_cnt + 4'd1;
      if (state == SHIFT && per_last && !bit_last) begin
        bit_cnt_n = bit_cnt + BW'(1);
        // the bit on the wire is always at the same end of shreg
        shreg_n   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
      end
      if (state == SHIFT && state_n == GAP) gap_cnt_n = 4'd0;
      else if (state == GAP && per_last)    gap_cnt_n = gap_cnt + 4'd1;
    end
    fifo_cnt_n = fifo_cnt + {1'b0, push} - {1'b0, load};
  end

  // ---------------------------------------------------------------------------
  // FSM outputs, derived from the state and datapath the next edge will hold
  // ---------------------------------------------------------------------------
  always_comb begin
    dout_n       = 1'b0;
    dout_valid_n = (state_n != IDLE);
    word_start_n = 1'b0;
    word_end_n   = 1'b0;
    if (state_n == SHIFT) begin
      dout_n       = (MSB_FIRST != 0) ? shreg_n[WIDTH-1] : shreg_n[0];
      word_start_n = (bit_cnt_n == '0);
      word_end_n   = (bit_cnt_n == BW'(WIDTH - 1));
    end
    busy_n       = (state_n != IDLE) || (fifo_cnt_n != 2'd0);
    in_ready_n   = (fifo_cnt_n != 2'd2);
    words_sent_n = words_sent + {7'd0, word_done};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // FIFO payload needs no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      shreg      <= '0;
      bit_cnt    <= '0;
      per_cnt    <= 4'd0;
      gap_cnt    <= 4'd0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      word_start <= 1'b0;
      word_end   <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      words_sent <= 8'd0;
    end else begin
      rd_ptr     <= rd_ptr ^ load;
      wr_ptr     <= wr_ptr ^ push;
      fifo_cnt   <= fifo_cnt_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      per_cnt    <= per_cnt_n;
      gap_cnt    <= gap_cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      word_start <= word_start_n;
      word_end   <= word_end_n;
      busy       <= busy_n;
      in_ready   <= in_ready_n;
      words_sent <= words_sent_n;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: four instances with different MSB_FIRST /
// GAP_BITS / BIT_PERIOD settings share clock and reset. A frame-position
// model (each word occupies (8+GAP)*BP clocks once started, queued words
// wait in a 2-deep list) predicts every output on every cycle.
module tb_word_serializer;
  localparam int NU = 4;
  localparam int MSB_A [NU] = '{1, 1, 0, 0};
  localparam int GAP_A [NU] = '{0, 2, 0, 3};
  localparam int BP_A  [NU] = '{1, 1, 2, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data    [NU];
  logic       in_valid   [NU];
  logic       in_ready   [NU];
  logic       dout       [NU];
  logic       dout_valid [NU];
  logic       word_start [NU];
  logic       word_end   [NU];
  logic       busy       [NU];
  logic [7:0] words_sent [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    word_serializer #(
      .WIDTH(8), .MSB_FIRST(MSB_A[g]), .GAP_BITS(GAP_A[g]), .BIT_PERIOD(BP_A[g])
    ) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .dout(dout[g]), .dout_valid(dout_valid[g]),
      .word_start(word_start[g]), .word_end(word_end[g]), .busy(busy[g]),
      .words_sent(words_sent[g])
    );
  end

  int errs = 0;
  int nchk = 0;

  // reference model state
  bit         m_act [NU];
  int         m_pos [NU];
  logic [7:0] m_cur [NU];
  logic [7:0] m_q   [NU][2];
  int         m_qn  [NU];
  int         m_sent[NU];
  bit         m_rdy [NU];
  bit         m_acc [NU];

  // source-side word lists (ring, ph = next to present, pt = next free)
  logic [7:0] pend [NU][512];
  int         ph   [NU];
  int         pt   [NU];
  bit         thr;

  int         grp   [NU];
  bit         prev1 [NU];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < NU; u++) begin
      int fd, fl;
      bit take;
      fd = 8 * BP_A[u];
      fl = (8 + GAP_A[u]) * BP_A[u];
      if (rst) begin
        m_act[u] = 0; m_pos[u] = 0; m_qn[u] = 0; m_sent[u] = 0;
        m_rdy[u] = 1; m_acc[u] = 0;
      end else begin
        m_acc[u] = in_valid[u] && m_rdy[u];
        take = !m_act[u];
        if (m_act[u]) begin
          m_pos[u]++;
          if (m_pos[u] == fd) m_sent[u] = (m_sent[u] + 1) % 256;
          if (m_pos[u] == fl) begin
            m_act[u] = 0;
            take = 1;
          end
        end
        // a word pushed on this edge is not yet visible to the pop
        if (take && m_qn[u] > 0) begin
          m_cur[u]  = m_q[u][0];
          m_q[u][0] = m_q[u][1];
          m_qn[u]--;
          m_act[u]  = 1;
          m_pos[u]  = 0;
        end
        if (m_acc[u]) begin
          m_q[u][m_qn[u]] = in_data[u];
          m_qn[u]++;
        end
        m_rdy[u] = (m_qn[u] < 2);
      end
    end
  endtask

  task automatic check_outputs();
    for (int u = 0; u < NU; u++) begin
      int idx, sh;
      bit data, e_dout, one;
      logic [7:0] t;
      data = m_act[u] && (m_pos[u] < 8 * BP_A[u]);
      idx  = m_pos[u] / BP_A[u];
      sh   = (MSB_A[u] != 0) ? 7 - idx : idx;
      t    = m_cur[u] >> sh;
      e_dout = data && t[0];
      chk($sformatf("u%0d dout", u),       32'(dout[u]),       32'(e_dout));
      chk($sformatf("u%0d dout_valid", u), 32'(dout_valid[u]), 32'(m_act[u]));
      chk($sformatf("u%0d word_start", u), 32'(word_start[u]), 32'(data && idx == 0));
      chk($sformatf("u%0d word_end", u),   32'(word_end[u]),   32'(data && idx == 7));
      chk($sformatf("u%0d busy", u),       32'(busy[u]),       32'(m_act[u] || m_qn[u] > 0));
      chk($sformatf("u%0d in_ready", u),   32'(in_ready[u]),   32'(m_rdy[u]));
      chk($sformatf("u%0d words_sent", u), 32'(words_sent[u]), 32'(m_sent[u]));
      one = dout_valid[u] && dout[u];
      if (one && !prev1[u]) grp[u]++;
      prev1[u] = one;
    end
  endtask

  task automatic feed();
    for (int u = 0; u < NU; u++) begin
      if (m_acc[u]) ph[u]++;
      in_valid[u] = (ph[u] < pt[u]) && (!thr || $urandom_range(3, 0) != 0);
      in_data[u]  = pend[u][ph[u] % 512];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    feed();
  endtask

  task automatic enq(input int u, input logic [7:0] d);
    pend[u][pt[u] % 512] = d;
    pt[u]++;
  endtask

  task automatic enq_all(input logic [7:0] d);
    for (int u = 0; u < NU; u++) enq(u, d);
  endtask

  function automatic bit all_idle();
    for (int u = 0; u < NU; u++)
      if (m_act[u] || m_qn[u] > 0 || ph[u] != pt[u] || in_valid[u]) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string tag, input int maxc);
    for (int i = 0; i < maxc && !all_idle(); i++) tick();
    chk(tag, 32'(all_idle()), 32'd1);
    repeat (3) tick();
  endtask

  task automatic drop_pending();
    for (int u = 0; u < NU; u++) begin
      pt[u] = ph[u];
      in_valid[u] = 1'b0;
    end
  endtask

  initial begin
    int g0, g1;
    bit hit;
    rst = 1'b1;
    thr = 1'b0;
    for (int u = 0; u < NU; u++) begin
      in_valid[u] = 1'b0; in_data[u] = 8'h00; ph[u] = 0; pt[u] = 0;
      grp[u] = 0; prev1[u] = 0; m_acc[u] = 0; m_rdy[u] = 1;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single word
    enq_all(8'h5D);
    wait_idle("idle_single", 200);

    // back-to-back words, fills shifter + FIFO
    enq_all(8'hF0); enq_all(8'h0F); enq_all(8'hAA);
    wait_idle("idle_b2b", 400);

    // gap bits split runs of ones into separate groups
    g0 = grp[0]; g1 = grp[1];
    enq_all(8'hFF); enq_all(8'hFF);
    wait_idle("idle_ff", 300);
    chk("groups_nogap", 32'(grp[0] - g0), 32'd1);
    chk("groups_gap",   32'(grp[1] - g1), 32'd2);

    // LSB first, stretched bits
    enq_all(8'h01);
    wait_idle("idle_lsb", 300);

    // reset during bit 4 of 0xFF with two more words queued
    enq_all(8'hFF); enq_all(8'h11); enq_all(8'h22);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = m_act[0] && m_pos[0] == 3 && m_cur[0] == 8'hFF;
    end
    chk("rst_reach_bit4", 32'(hit), 32'd1);
    rst = 1'b1;
    drop_pending();
    tick();
    rst = 1'b0;
    chk("rst_dout_valid", 32'(dout_valid[0]), 32'd0);
    chk("rst_busy",       32'(busy[0]),       32'd0);
    chk("rst_in_ready",   32'(in_ready[0]),   32'd1);
    chk("rst_words_sent", 32'(words_sent[0]), 32'd0);
    repeat (40) tick();

    // randomized words with throttled valid
    thr = 1'b1;
    for (int n = 0; n < 200; n++)
      for (int u = 0; u < NU; u++) enq(u, 8'($urandom));
    wait_idle("idle_random", 9000);
    thr = 1'b0;

    // words_sent wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 256; n++) enq(0, 8'h80);
    wait_idle("idle_256", 4000);
    chk("words_sent_256", 32'(words_sent[0]), 32'd0);
    enq(0, 8'h80);
    wait_idle("idle_257", 100);
    chk("words_sent_257", 32'(words_sent[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
